// File: rtl/dma_master_pkg.sv
// Shared types and constants for the DMA master: bus widths, strobe polarities,
// FSM state encoding and the latched transfer job.
package dma_master_pkg;

    localparam int unsigned ADDR_W          = 30;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned LEN_W           = 16;
    localparam int unsigned WAIT_W          = 16;
    localparam int unsigned DEF_TIMEOUT_CYC = 255;

    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RD,
        WR,
        DONE
    } dmaState_e;

    // Transfer progress; wrPend remembers which access to retry after a lost grant.
    typedef struct packed {
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
        logic [LEN_W-1:0]  cnt;
        logic              wrPend;
    } dmaJob_t;

    function automatic logic [ADDR_W-1:0] addrInc(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/dma_master_wdog.sv
// Per-access wait counter: counts cycles an access stays pending, clears otherwise.
module dma_master_wdog
    import dma_master_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic [WAIT_W-1:0] waitCnt
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            waitCnt <= '0;
        end else if (run) begin
            waitCnt <= waitCnt + WAIT_W'(1);
        end else begin
            waitCnt <= '0;
        end
    end

endmodule

// File: rtl/dma_master.sv
// DMA master: copies Len words from SrcAddr to DstAddr as alternating read/write
// accesses on the shared bus, retrying on grant loss and aborting on slave timeout.
module dma_master
    import dma_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] SrcAddr,
    input  logic [ADDR_W-1:0] DstAddr,
    input  logic [LEN_W-1:0]  Len,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic              BusReq_,
    input  logic              BusGrnt_,
    output logic [ADDR_W-1:0] BusAddr,
    output logic              BusAs_,
    output logic              BusRW,
    output logic [DATA_W-1:0] BusWrData,
    input  logic [DATA_W-1:0] BusRdData,
    input  logic              BusRdy_
);

    dmaState_e         state, stateNxt;
    dmaJob_t           job, jobNxt;
    logic [DATA_W-1:0] rdBuf, rdBufNxt;
    logic              busyNxt, doneNxt, errNxt;
    logic              reqNxt, asNxt, rwNxt;
    logic [ADDR_W-1:0] addrNxt;
    logic [DATA_W-1:0] wrDataNxt;
    logic              launch;
    logic [WAIT_W-1:0] waitCnt;
    logic              timeoutHit;

    // Counter runs only while an access that was already on the bus stays on it.
    dma_master_wdog u_wdog (
        .clk     (clk),
        .reset   (reset),
        .run     ((BusAs_ == ENABLE_) && (asNxt == ENABLE_)),
        .waitCnt (waitCnt)
    );

    assign timeoutHit = (waitCnt == WAIT_W'(TIMEOUT_CYC - 1));

    // Next-state and next-output logic.
    always_comb begin
        stateNxt  = state;
        jobNxt    = job;
        rdBufNxt  = rdBuf;
        busyNxt   = Busy;
        doneNxt   = 1'b0;
        errNxt    = 1'b0;
        reqNxt    = BusReq_;
        asNxt     = BusAs_;
        rwNxt     = BusRW;
        addrNxt   = BusAddr;
        wrDataNxt = BusWrData;
        launch    = 1'b0;

        unique case (state)
            IDLE: begin
                if (Start) begin
                    if (Len != '0) begin
                        jobNxt   = '{src: SrcAddr, dst: DstAddr, cnt: Len, wrPend: 1'b0};
                        busyNxt  = 1'b1;
                        reqNxt   = ENABLE_;
                        stateNxt = REQ;
                    end else begin
                        doneNxt  = 1'b1;
                        stateNxt = DONE;
                    end
                end
            end
            REQ: begin
                if (BusGrnt_ == ENABLE_) begin
                    launch   = 1'b1;
                    stateNxt = job.wrPend ? WR : RD;
                end
            end
            RD, WR: begin
                // BusAs_ high here is the one-cycle gap before the access starts.
                if (BusAs_ == DISABLE_) begin
                    if (BusGrnt_ == ENABLE_) begin
                        launch = 1'b1;
                    end else begin
                        stateNxt = REQ;
                    end
                end else if (BusRdy_ == ENABLE_) begin
                    asNxt = DISABLE_;
                    if (state == RD) begin
                        rdBufNxt      = BusRdData;
                        jobNxt.wrPend = 1'b1;
                        stateNxt      = WR;
                    end else begin
                        jobNxt.src    = addrInc(job.src);
                        jobNxt.dst    = addrInc(job.dst);
                        jobNxt.cnt    = job.cnt - LEN_W'(1);
                        jobNxt.wrPend = 1'b0;
                        if (job.cnt == LEN_W'(1)) begin
                            doneNxt  = 1'b1;
                            reqNxt   = DISABLE_;
                            stateNxt = DONE;
                        end else begin
                            stateNxt = RD;
                        end
                    end
                end else if (BusGrnt_ == DISABLE_) begin
                    asNxt    = DISABLE_;
                    stateNxt = REQ;
                end else if (timeoutHit) begin
                    asNxt      = DISABLE_;
                    reqNxt     = DISABLE_;
                    doneNxt    = 1'b1;
                    errNxt     = 1'b1;
                    jobNxt.cnt = '0;
                    stateNxt   = DONE;
                end
            end
            DONE: begin
                busyNxt  = 1'b0;
                stateNxt = IDLE;
            end
            default: begin
                stateNxt = IDLE;
            end
        endcase

        if (launch) begin
            asNxt   = ENABLE_;
            rwNxt   = job.wrPend ? WRITE : READ;
            addrNxt = job.wrPend ? job.dst : job.src;
            if (job.wrPend) begin
                wrDataNxt = rdBuf;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            job       <= '0;
            rdBuf     <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Err       <= 1'b0;
            BusReq_   <= DISABLE_;
            BusAs_    <= DISABLE_;
            BusRW     <= READ;
            BusAddr   <= '0;
            BusWrData <= '0;
        end else begin
            state     <= stateNxt;
            job       <= jobNxt;
            rdBuf     <= rdBufNxt;
            Busy      <= busyNxt;
            Done      <= doneNxt;
            Err       <= errNxt;
            BusReq_   <= reqNxt;
            BusAs_    <= asNxt;
            BusRW     <= rwNxt;
            BusAddr   <= addrNxt;
            BusWrData <= wrDataNxt;
        end
    end

endmodule

// File: tb/tb_dma_master.sv
// Directed and randomized transfers against a reactive slave/arbiter; completed
// bus accesses are compared with the copy sequence derived from Src/Dst/Len.
module tb_dma_master;
    import dma_master_pkg::*;

    localparam int unsigned TMO    = 255;
    localparam int          BUDGET = 3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [29:0] SrcAddr, DstAddr;
    logic [15:0] Len;
    logic        Busy, Done, Err;
    logic        BusReq_, BusGrnt_;
    logic [29:0] BusAddr;
    logic        BusAs_, BusRW;
    logic [31:0] BusWrData, BusRdData;
    logic        BusRdy_;

    logic [31:0] salt;
    int          nChecks = 0;
    int          nPass   = 0;
    int          nFail   = 0;

    always #5 clk = ~clk;

    dma_master dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (Start),
        .SrcAddr   (SrcAddr),
        .DstAddr   (DstAddr),
        .Len       (Len),
        .Busy      (Busy),
        .Done      (Done),
        .Err       (Err),
        .BusReq_   (BusReq_),
        .BusGrnt_  (BusGrnt_),
        .BusAddr   (BusAddr),
        .BusAs_    (BusAs_),
        .BusRW     (BusRW),
        .BusWrData (BusWrData),
        .BusRdData (BusRdData),
        .BusRdy_   (BusRdy_)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        assert (got === exp) nPass++;
        else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] memVal(input logic [29:0] a);
        return {a, 2'b10} ^ salt;
    endfunction

    task automatic checkIdleOutputs(input string tag);
        check({tag, "_busreq"}, 32'(BusReq_), 32'(1));
        check({tag, "_busas"},  32'(BusAs_),  32'(1));
        check({tag, "_busy"},   32'(Busy),    32'(0));
        check({tag, "_done"},   32'(Done),    32'(0));
    endtask

    task automatic runXfer(input logic [29:0] src, input logic [29:0] dst, input logic [15:0] len,
                           input int minWait, input int maxWait, input bit neverRdy,
                           input int stealCyc, input bit rstInWr);
        logic [29:0] expAddr[$];
        logic        expRw[$];
        logic [31:0] expData[$];
        logic [29:0] obsAddr[$];
        logic        obsRw[$];
        logic [31:0] obsData[$];
        int          startCyc[$];
        int          endCyc[$];
        int          cyc = 0, doneCnt = 0, doneAt = -1, accLow = 0, wt = 0, accStart = 0;
        bit          prevAsHigh = 1'b1, reqLow = 1'b0, doneErr = 1'b0, finished = 1'b0;
        bit          steal, rstHit = 1'b0, sawBad = 1'b0;
        logic [29:0] accAddr = '0;
        logic        accRw = 1'b1;
        logic [31:0] accWd = '0;

        salt = $urandom;
        if (!neverRdy && !rstInWr) begin
            for (int i = 0; i < int'(len); i++) begin
                expAddr.push_back(src + 30'(i)); expRw.push_back(1'b1); expData.push_back(memVal(src + 30'(i)));
                expAddr.push_back(dst + 30'(i)); expRw.push_back(1'b0); expData.push_back(memVal(src + 30'(i)));
            end
        end

        Start = 1'b1; SrcAddr = src; DstAddr = dst; Len = len;
        @(negedge clk);
        Start = 1'b0;
        check("busy_after_start", 32'(Busy), 32'(len != 16'd0));

        while (!finished && cyc < BUDGET) begin
            steal = (stealCyc >= 0) && (cyc >= stealCyc) && (cyc < stealCyc + 2);
            if (!BusReq_) reqLow = 1'b1;
            if (Done) begin
                doneCnt++; doneAt = cyc; doneErr = Err; finished = 1'b1;
                check("done_busreq", 32'(BusReq_), 32'(1));
                check("done_busas",  32'(BusAs_),  32'(1));
            end
            // Start pulses during a transfer must be ignored.
            if (cyc == 3 && len != 16'd0 && !finished) begin
                Start = 1'b1; SrcAddr = 30'($urandom); DstAddr = 30'($urandom); Len = 16'($urandom_range(9, 1));
            end else begin
                Start = 1'b0;
            end
            BusGrnt_  = steal ? 1'b1 : BusReq_;
            BusRdData = $urandom;
            if (!BusAs_) begin
                if (prevAsHigh) begin
                    accStart = cyc; accAddr = BusAddr; accRw = BusRW; accWd = BusWrData; accLow = 0;
                    wt = int'($urandom_range(maxWait, minWait));
                end else begin
                    check("hold_addr", 32'(BusAddr), 32'(accAddr));
                    check("hold_rw",   32'(BusRW),   32'(accRw));
                    if (!accRw) check("hold_wdata", BusWrData, accWd);
                end
                accLow++;
                if (rstInWr && BusRW == WRITE) begin
                    #1 reset = 1'b1;
                    #1;
                    check("rst_busreq", 32'(BusReq_),  32'(1));
                    check("rst_busas",  32'(BusAs_),   32'(1));
                    check("rst_rw",     32'(BusRW),    32'(1));
                    check("rst_addr",   32'(BusAddr),  32'(0));
                    check("rst_wdata",  BusWrData,     32'(0));
                    check("rst_busy",   32'(Busy),     32'(0));
                    check("rst_done",   32'(Done),     32'(0));
                    check("rst_err",    32'(Err),      32'(0));
                    rstHit = 1'b1;
                    break;
                end
                if (!steal && !neverRdy && accLow > wt) begin
                    BusRdy_ = 1'b0;
                    if (accRw) BusRdData = memVal(accAddr);
                    obsAddr.push_back(accAddr); obsRw.push_back(accRw);
                    obsData.push_back(accRw ? memVal(accAddr) : accWd);
                    startCyc.push_back(accStart); endCyc.push_back(cyc);
                end else begin
                    BusRdy_ = 1'b1;
                end
            end else begin
                BusRdy_ = 1'($urandom);
            end
            prevAsHigh = BusAs_;
            @(negedge clk);
            cyc++;
        end
        Start = 1'b0;

        if (rstInWr) begin
            check("rst_in_wr_reached", 32'(rstHit), 32'(1));
            @(negedge clk);
            reset = 1'b0; BusGrnt_ = 1'b1; BusRdy_ = 1'b1;
            repeat (6) begin
                @(negedge clk);
                if (Done || Busy || !BusReq_ || !BusAs_) sawBad = 1'b1;
            end
            check("rst_no_done_after", 32'(sawBad), 32'(0));
            return;
        end

        check("xfer_finished", 32'(finished), 32'(1));
        check("done_count", 32'(doneCnt), 32'(1));
        check("done_err", 32'(doneErr), 32'(neverRdy));
        check("access_count", 32'(obsAddr.size()), 32'(expAddr.size()));
        for (int k = 0; k < expAddr.size() && k < obsAddr.size(); k++) begin
            check("acc_addr", 32'(obsAddr[k]), 32'(expAddr[k]));
            check("acc_rw",   32'(obsRw[k]),   32'(expRw[k]));
            check("acc_data", obsData[k],      expData[k]);
        end
        if (stealCyc < 0) begin
            for (int k = 1; k < startCyc.size(); k++)
                check("as_gap_one_cycle", 32'(startCyc[k] - endCyc[k-1]), 32'(2));
        end
        if (len == 16'd0) begin
            check("len0_no_busreq", 32'(reqLow), 32'(0));
            check("len0_done_latency", 32'(doneAt), 32'(0));
        end
        if (neverRdy) check("timeout_wait_cycles", 32'(accLow), 32'(TMO));
        checkIdleOutputs("post_done");
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; SrcAddr = '0; DstAddr = '0; Len = '0;
        BusGrnt_ = 1'b1; BusRdy_ = 1'b1; BusRdData = '0; salt = '0;
        repeat (2) @(negedge clk);
        check("reset_busreq", 32'(BusReq_), 32'(1));
        check("reset_busas",  32'(BusAs_),  32'(1));
        check("reset_rw",     32'(BusRW),   32'(1));
        check("reset_addr",   32'(BusAddr), 32'(0));
        check("reset_wdata",  BusWrData,    32'(0));
        check("reset_busy",   32'(Busy),    32'(0));
        check("reset_done",   32'(Done),    32'(0));
        check("reset_err",    32'(Err),     32'(0));
        reset = 1'b0;
        @(negedge clk);

        runXfer(30'h100, 30'h200, 16'd3, 0, 0, 1'b0, -1, 1'b0);
        runXfer(30'($urandom), 30'($urandom), 16'd3, 4, 4, 1'b0, -1, 1'b0);
        runXfer(30'h40, 30'h80, 16'd0, 0, 0, 1'b0, -1, 1'b0);
        runXfer(30'h3FFF_FFFF, 30'h1000, 16'd2, 0, 2, 1'b0, -1, 1'b0);
        runXfer(30'h500, 30'h600, 16'd2, 0, 0, 1'b1, -1, 1'b0);
        runXfer(30'h700, 30'h900, 16'd3, 1, 2, 1'b0, 5, 1'b0);
        for (int t = 0; t < 6; t++)
            runXfer(30'($urandom), 30'($urandom), 16'($urandom_range(5, 1)), 0, 3, 1'b0, -1, 1'b0);
        runXfer(30'h123, 30'h456, 16'd2, 3, 3, 1'b0, -1, 1'b1);
        runXfer(30'h10, 30'h20, 16'd1, 0, 1, 1'b0, -1, 1'b0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/dma_master.md
DMA_MASTER -- requirements
Module: dma_master

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: maximum cycles one access waits for Rdy_ before abort.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 Start  in  1  one-cycle command pulse; sampled only in IDLE.
REQ-005 SrcAddr, DstAddr  in  30 each  word addresses, latched on accepted Start.
REQ-006 Len  in  16  word count, latched on accepted Start.
REQ-007 Busy  out  1  high from accepted Start until Done.
REQ-008 Done  out  1  one-cycle completion pulse.
REQ-009 Err  out  1  valid with Done; 1 = timeout abort.
REQ-010 BusReq_  out  1  bus request, active-low.
REQ-011 BusGrnt_  in  1  arbiter grant, active-low.
REQ-012 BusAddr  out  30  word address.
REQ-013 BusAs_  out  1  address strobe, active-low.
REQ-014 BusRW  out  1  READ=1, WRITE=0.
REQ-015 BusWrData  out  32  write data.
REQ-016 BusRdData  in  32  read data, valid in the cycle Rdy_ is low.
REQ-017 BusRdy_  in  1  slave ready, active-low.

Function
REQ-018 States IDLE, REQ, RD, WR, DONE; one access in flight at most.
REQ-019 IDLE: Start with Len!=0 latches SrcAddr/DstAddr/Len, sets Busy, goes to REQ; Start with Len=0 pulses Done (Err=0) next cycle, no bus activity.
REQ-020 Start while Busy is ignored.
REQ-021 REQ: BusReq_=0; on BusGrnt_=0 go to RD next cycle.
REQ-022 BusReq_ stays 0 from REQ through the final access; deasserted in DONE.
REQ-023 RD: BusAs_=0, BusRW=READ, BusAddr=current src; Addr/As_/RW held stable until a cycle with BusRdy_=0.
REQ-024 RD completion: BusRdData captured into 32-bit buffer in the BusRdy_=0 cycle; next cycle enter WR.
REQ-025 WR: BusAs_=0, BusRW=WRITE, BusAddr=current dst, BusWrData=buffer, held until BusRdy_=0.
REQ-026 WR completion: src+1, dst+1, count-1; count reaching 0 -> DONE, else -> RD.
REQ-027 Address increment wraps modulo 2^30 (0x3FFFFFFF -> 0).
REQ-028 BusAs_=1 for exactly one cycle between consecutive accesses (RD->WR, WR->RD).
REQ-029 BusGrnt_=1 observed in RD/WR before that access completes: drop BusAs_, return to REQ, retry the same access unchanged.
REQ-030 Per-access wait counter clears at access start; reaching TIMEOUT_CYC without BusRdy_=0 -> DONE with Err=1, remaining count discarded.
REQ-031 DONE: one cycle; Done=1, Busy=0 next cycle, BusReq_=1, BusAs_=1; return to IDLE.
REQ-032 BusRdy_ outside an own access (BusAs_=1) is ignored.

Reset
REQ-033 Reset asserted at any time forces IDLE within the same cycle: BusReq_=1, BusAs_=1, BusRW=READ, BusAddr=0, BusWrData=0, Busy=0, Done=0, Err=0, counters and buffer 0.
REQ-034 Reset mid-transfer abandons the transfer with no Done pulse.

Structure
REQ-035 State encodings, READ/WRITE and active-low ENABLE_/DISABLE_ constants, and default TIMEOUT_CYC live in shared header dma.vh alongside existing bus definitions.
REQ-036 Single module; instantiated on master port M2 of the existing bus.

Verification
REQ-037 Len=3, Src=0x100, Dst=0x200, zero-wait slave -> reads 0x100..0x102 then writes 0x200..0x202 interleaved, one Done, Err=0, data matches.
REQ-038 Slave Rdy_ delayed 4 cycles per access -> Addr/As_/RW stable all 4 cycles, data correct.
REQ-039 Len=0 Start -> Done next cycle, BusReq_ never low.
REQ-040 Src=0x3FFFFFFF, Len=2 -> second read at address 0.
REQ-041 Slave never asserts Rdy_ -> Done with Err=1 after 255 wait cycles, bus released.
REQ-042 Reset asserted during WR -> all outputs to reset values immediately, no Done.
